snake_body_ctrl: RTL and testbench

SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_body_ram.sv | 26 ++
 rtl/snake_body_ctrl.sv | 160 ++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake body controller: position packing and FSM states.
package snake_pkg;

  localparam int POS_W = 8;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_SCAN,
    ST_COMMIT,
    ST_OVER
  } state_t;

  function automatic pos_t pack_pos(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

  function automatic logic [3:0] pos_x(input pos_t p);
    return p[7:4];
  endfunction

  function automatic logic [3:0] pos_y(input pos_t p);
    return p[3:0];
  endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Circular body store: one synchronous write port, one combinational read port
// shared between the collision scan, the tail pop and the newest-entry lookup.
module snake_body_ram
  import snake_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pos_t              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output pos_t              rd_data
);

  pos_t mem [DEPTH];

  // NOTE: storage has no reset; every entry read is written by INIT or COMMIT first.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: accepts head moves, scans the body for self-collision
// one entry per cycle, then commits the head and pops or keeps the tail.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int PTR_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic [POS_W-1:0] head_pos,
  input  logic [POS_W-1:0] food_pos,
  output logic [POS_W-1:0] tail_pos,
  output logic             tail_clr,
  output logic             head_set,
  output logic             food_req,
  output logic             init,
  output logic [PTR_W:0]   length,
  output logic             busy,
  output logic             game_over,
  output logic             tick_drop
);

  localparam logic [PTR_W:0]   FULL_LEN = (PTR_W + 1)'(MAX_LEN);
  localparam logic [PTR_W:0]   LEN_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W - 1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [PTR_W:0]   length_q, scan_idx;
  pos_t             cand, tail_q;
  logic             grow;

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr, rd_addr;
  pos_t             wr_data, rd_data;

  logic tick_accept, hit, scan_last, full, pop, in_commit;

  snake_body_ram #(
    .DEPTH (MAX_LEN),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // NOTE: every always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    rd_addr = head_ptr;
    case (state)
      ST_SCAN:   rd_addr = tail_ptr + scan_idx[PTR_W-1:0];
      ST_COMMIT: rd_addr = tail_ptr;
      default:   rd_addr = head_ptr;
    endcase
  end

  // In WAIT the read port shows the newest entry, so a repeated head is filtered here.
  assign tick_accept = (state == ST_WAIT) && tick && (head_pos != rd_data);
  assign full        = (length_q == FULL_LEN);
  assign pop         = !grow || full;
  // The tail cell is vacated by a non-growing move, so it cannot be hit.
  assign hit         = (rd_data == cand) && !((scan_idx == '0) && !grow);
  assign scan_last   = ((scan_idx + LEN_ONE) == length_q);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = head_ptr + PTR_ONE;
    wr_data = cand;
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = head_pos;
    end else if (state == ST_COMMIT) begin
      wr_en = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_OVER: if (start) state_next = ST_INIT;
      ST_INIT:          state_next = ST_WAIT;
      ST_WAIT:          if (tick_accept) state_next = ST_SCAN;
      ST_SCAN: begin
        if (hit)            state_next = ST_OVER;
        else if (scan_last) state_next = ST_COMMIT;
      end
      ST_COMMIT:        state_next = ST_WAIT;
      default:          state_next = ST_IDLE;
    endcase
  end

  // head_ptr indexes the newest entry; a commit writes one slot past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      length_q <= '0;
      scan_idx <= '0;
      cand     <= '0;
      grow     <= 1'b0;
      tail_q   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          head_ptr <= '0;
          tail_ptr <= '0;
          length_q <= LEN_ONE;
          scan_idx <= '0;
        end
        ST_WAIT: begin
          if (tick_accept) begin
            cand     <= head_pos;
            grow     <= (head_pos == food_pos);
            scan_idx <= '0;
          end
        end
        ST_SCAN: scan_idx <= scan_idx + LEN_ONE;
        ST_COMMIT: begin
          head_ptr <= head_ptr + PTR_ONE;
          if (pop) begin
            tail_ptr <= tail_ptr + PTR_ONE;
            tail_q   <= rd_data;
          end
          if (grow && !full) length_q <= length_q + LEN_ONE;
        end
        default: ;
      endcase
    end
  end

  // Pulses are masked while reset is high so an interrupted commit never leaks out.
  assign in_commit = !reset && (state == ST_COMMIT);

  always_comb begin
    init      = !reset && (state == ST_INIT);
    head_set  = in_commit;
    food_req  = in_commit && grow;
    tail_clr  = in_commit && pop;
    tail_pos  = (in_commit && pop) ? rd_data : tail_q;
    busy      = reset || (state != ST_WAIT);
    game_over = !reset && (state == ST_OVER);
    tick_drop = !reset && tick && (state != ST_WAIT);
    length    = length_q;
  end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl: vector tables, reset corner cases and
// random moves compared against a queue-based model of the snake body.
module tb_snake_body_ctrl;
  import snake_pkg::*;

  typedef enum int {OP_START, OP_MOVE} op_t;

  typedef struct {
    op_t  op;
    pos_t head;
    pos_t food;
    bit   inject;
    int   e_food;
    int   e_clr;
    int   e_tpos;
    int   e_len;
    int   e_over;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, tick, sel;
  pos_t head_pos, food_pos;

  pos_t       tail_pos_a, tail_pos_b;
  logic       tail_clr_a, head_set_a, food_req_a, init_a, busy_a, game_over_a, tick_drop_a;
  logic       tail_clr_b, head_set_b, food_req_b, init_b, busy_b, game_over_b, tick_drop_b;
  logic [5:0] length_a;
  logic [2:0] length_b;

  int o_tail_pos, o_tail_clr, o_head_set, o_food_req, o_init, o_len, o_busy, o_game_over, o_tick_drop;

  int   n_cmp = 0;
  int   n_bad = 0;
  pos_t body_q[$];
  pos_t last_tail;
  bit   running;
  int   model_max;
  vec_t vecs[$];

  snake_body_ctrl #(.MAX_LEN(32), .PTR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .head_pos(head_pos), .food_pos(food_pos),
    .tail_pos(tail_pos_a), .tail_clr(tail_clr_a), .head_set(head_set_a),
    .food_req(food_req_a), .init(init_a), .length(length_a), .busy(busy_a),
    .game_over(game_over_a), .tick_drop(tick_drop_a)
  );

  snake_body_ctrl #(.MAX_LEN(4), .PTR_W(2)) dut4 (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .head_pos(head_pos), .food_pos(food_pos),
    .tail_pos(tail_pos_b), .tail_clr(tail_clr_b), .head_set(head_set_b),
    .food_req(food_req_b), .init(init_b), .length(length_b), .busy(busy_b),
    .game_over(game_over_b), .tick_drop(tick_drop_b)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_tail_pos  = sel ? int'(tail_pos_b)  : int'(tail_pos_a);
    o_tail_clr  = sel ? int'(tail_clr_b)  : int'(tail_clr_a);
    o_head_set  = sel ? int'(head_set_b)  : int'(head_set_a);
    o_food_req  = sel ? int'(food_req_b)  : int'(food_req_a);
    o_init      = sel ? int'(init_b)      : int'(init_a);
    o_len       = sel ? int'(length_b)    : int'(length_a);
    o_busy      = sel ? int'(busy_b)      : int'(busy_a);
    o_game_over = sel ? int'(game_over_b) : int'(game_over_a);
    o_tick_drop = sel ? int'(tick_drop_b) : int'(tick_drop_a);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit noisy);
    reset = 1'b1; start = noisy; tick = noisy;
    @(negedge clk);
    check("rst_busy", o_busy, 1);
    check("rst_pulses", o_head_set + o_tail_clr + o_food_req + o_init + o_tick_drop, 0);
    check("rst_game_over", o_game_over, 0);
    tick_clk();
    tick_clk();
    reset = 1'b0; start = 1'b0; tick = 1'b0;
    @(negedge clk);
    check("rst_length", o_len, 0);
    check("rst_tail_pos", o_tail_pos, 0);
    check("rst_idle_busy", o_busy, 1);
    check("rst_no_init", o_init, 0);
    tick_clk();
    body_q.delete();
    last_tail = '0;
    running = 1'b0;
  endtask

  task automatic start_game(input pos_t h);
    if (running) do_reset(1'b0);
    head_pos = h; start = 1'b1;
    tick_clk();
    start = 1'b0;
    @(negedge clk);
    check("init_pulse", o_init, 1);
    check("init_busy", o_busy, 1);
    tick_clk();
    @(negedge clk);
    check("init_done", o_init, 0);
    check("start_length", o_len, 1);
    check("start_busy", o_busy, 0);
    check("start_game_over", o_game_over, 0);
    check("start_tail_hold", o_tail_pos, int'(last_tail));
    tick_clk();
    body_q.delete();
    body_q.push_back(h);
    running = 1'b1;
  endtask

  // Applies one tick in WAIT and predicts timing and pulses from the body queue.
  task automatic move(input pos_t h, input pos_t f, input bit inject,
                      output int r_food, output int r_clr, output int r_tpos,
                      output int r_len, output int r_over);
    int n, hit_k, commit_c, over_c, idle_c, fr, tc, drops, viol, tp;
    int exp_commit, exp_over, exp_idle;
    bit ign, grow, pop, ok;
    n     = body_q.size();
    ign   = (h == body_q[n-1]);
    grow  = (h == f);
    pop   = !grow || (n == model_max);
    hit_k = -1;
    if (!ign)
      for (int i = 0; i < n; i++)
        if (hit_k < 0 && body_q[i] == h && !(i == 0 && !grow)) hit_k = i;
    ok = !ign && (hit_k < 0);
    commit_c = -1; over_c = -1; idle_c = -1; tp = -1;
    fr = 0; tc = 0; drops = 0; viol = 0;

    head_pos = h; food_pos = f; tick = 1'b1;
    @(negedge clk);
    check("accept_idle", o_busy, 0);
    check("accept_no_drop", o_tick_drop, 0);
    tick_clk();
    tick = inject && !ign;
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      if (o_head_set != 0 && commit_c < 0) commit_c = c;
      if (o_tail_clr != 0) tp = o_tail_pos;
      if (o_game_over != 0 && over_c < 0) over_c = c;
      if (o_busy == 0 && idle_c < 0) idle_c = c;
      fr += o_food_req; tc += o_tail_clr; drops += o_tick_drop;
      if (o_init != 0 || (o_food_req != 0 && o_head_set == 0) || (o_tail_clr != 0 && o_head_set == 0))
        viol++;
      tick_clk();
      tick = 1'b0;
    end

    if (ign) begin
      exp_commit = -1; exp_over = -1; exp_idle = 1;
    end else if (hit_k >= 0) begin
      exp_commit = -1; exp_over = hit_k + 2; exp_idle = -1;
    end else begin
      exp_commit = n + 1; exp_over = -1; exp_idle = n + 2;
    end
    check("commit_cycle", commit_c, exp_commit);
    check("over_cycle", over_c, exp_over);
    check("idle_cycle", idle_c, exp_idle);
    check("food_req_count", fr, (ok && grow) ? 1 : 0);
    check("tail_clr_count", tc, (ok && pop) ? 1 : 0);
    if (ok && pop) check("tail_pos", tp, int'(body_q[0]));
    check("tick_drop_count", drops, (inject && !ign) ? 1 : 0);
    check("pulse_overlap", viol, 0);

    if (ok) begin
      body_q.push_back(h);
      if (pop) last_tail = body_q.pop_front();
    end
    if (hit_k >= 0) running = 1'b0;
    check("length", o_len, body_q.size());
    check("tail_hold", o_tail_pos, int'(last_tail));
    check("game_over", o_game_over, running ? 0 : 1);

    r_food = fr; r_clr = tc;
    r_tpos = (tc > 0) ? tp : o_tail_pos;
    r_len  = o_len; r_over = o_game_over;
  endtask

  task automatic add(input op_t op, input pos_t h, input pos_t f, input bit inj,
                     input int ef, input int ec, input int et, input int el, input int eo);
    vec_t v;
    v = '{op, h, f, inj, ef, ec, et, el, eo};
    vecs.push_back(v);
  endtask

  task automatic run_vecs();
    int rf, rc, rt, rl, ro;
    foreach (vecs[i]) begin
      if (vecs[i].op == OP_START) begin
        start_game(vecs[i].head);
        rf = 0; rc = 0; rt = o_tail_pos; rl = o_len; ro = o_game_over;
      end else begin
        move(vecs[i].head, vecs[i].food, vecs[i].inject, rf, rc, rt, rl, ro);
      end
      check($sformatf("vec%0d_food_req", i), rf, vecs[i].e_food);
      check($sformatf("vec%0d_tail_clr", i), rc, vecs[i].e_clr);
      check($sformatf("vec%0d_tail_pos", i), rt, vecs[i].e_tpos);
      check($sformatf("vec%0d_length", i), rl, vecs[i].e_len);
      check($sformatf("vec%0d_game_over", i), ro, vecs[i].e_over);
    end
    vecs.delete();
  endtask

  task automatic rand_move();
    pos_t nb, h, f;
    logic [3:0] x, y;
    int rf, rc, rt, rl, ro;
    if (!running) begin
      start_game(pos_t'($urandom));
      return;
    end
    nb = body_q[body_q.size()-1];
    x = pos_x(nb); y = pos_y(nb);
    case ($urandom_range(0, 3))
      0:       x = x + 4'd1;
      1:       x = x - 4'd1;
      2:       y = y + 4'd1;
      default: y = y - 4'd1;
    endcase
    h = ($urandom_range(0, 7) == 0) ? pos_t'($urandom) : pack_pos(x, y);
    f = ($urandom_range(0, 2) == 0) ? h : pos_t'($urandom);
    move(h, f, $urandom_range(0, 4) == 0, rf, rc, rt, rl, ro);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; reset = 1'b1; start = 1'b0; tick = 1'b0;
    head_pos = '0; food_pos = '0;
    model_max = 32; running = 1'b0; last_tail = '0;
    do_reset(1'b1);

    // Basic moves, eating, repeated head, dropped tick, tail-exclusion and collision.
    add(OP_START, 8'h44, 8'h99, 0, 0, 0, 8'h00, 1, 0);
    add(OP_MOVE,  8'h54, 8'h99, 0, 0, 1, 8'h44, 1, 0);
    add(OP_MOVE,  8'h64, 8'h99, 0, 0, 1, 8'h54, 1, 0);
    add(OP_MOVE,  8'h74, 8'h99, 0, 0, 1, 8'h64, 1, 0);
    add(OP_MOVE,  8'h84, 8'h84, 0, 1, 0, 8'h64, 2, 0);
    add(OP_MOVE,  8'h84, 8'h99, 0, 0, 0, 8'h64, 2, 0);
    add(OP_MOVE,  8'h94, 8'h99, 1, 0, 1, 8'h74, 2, 0);
    add(OP_START, 8'h11, 8'h99, 0, 0, 0, 8'h00, 1, 0);
    add(OP_MOVE,  8'h12, 8'h12, 0, 1, 0, 8'h00, 2, 0);
    add(OP_MOVE,  8'h22, 8'h22, 0, 1, 0, 8'h00, 3, 0);
    add(OP_MOVE,  8'h21, 8'h21, 0, 1, 0, 8'h00, 4, 0);
    add(OP_MOVE,  8'h20, 8'h20, 0, 1, 0, 8'h00, 5, 0);
    add(OP_MOVE,  8'h12, 8'h99, 0, 0, 0, 8'h00, 5, 1);
    add(OP_START, 8'h11, 8'h99, 0, 0, 0, 8'h00, 1, 0);
    add(OP_MOVE,  8'h12, 8'h12, 0, 1, 0, 8'h00, 2, 0);
    add(OP_MOVE,  8'h22, 8'h22, 0, 1, 0, 8'h00, 3, 0);
    add(OP_MOVE,  8'h21, 8'h21, 0, 1, 0, 8'h00, 4, 0);
    add(OP_MOVE,  8'h20, 8'h20, 0, 1, 0, 8'h00, 5, 0);
    add(OP_MOVE,  8'h11, 8'h99, 0, 0, 1, 8'h11, 5, 0);
    run_vecs();

    // start while in WAIT is ignored.
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    @(negedge clk);
    check("start_in_wait_init", o_init, 0);
    check("start_in_wait_busy", o_busy, 0);
    check("start_in_wait_length", o_len, 5);
    tick_clk();

    // Reset during SCAN.
    head_pos = 8'hEE; food_pos = 8'h99; tick = 1'b1;
    tick_clk();
    tick = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_scan_head_set", o_head_set, 0);
    tick_clk();
    reset = 1'b0;
    begin
      int pulses = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        pulses += o_head_set + o_tail_clr + o_food_req + o_init + o_game_over;
        if (c == 0) begin
          check("rst_scan_busy", o_busy, 1);
          check("rst_scan_length", o_len, 0);
          check("rst_scan_tail_pos", o_tail_pos, 0);
        end
        tick_clk();
      end
      check("rst_scan_pulses", pulses, 0);
    end
    body_q.delete(); last_tail = '0; running = 1'b0;

    // Reset during COMMIT at length 1.
    start_game(8'h30);
    head_pos = 8'h31; food_pos = 8'h99; tick = 1'b1;
    tick_clk();
    tick = 1'b0;
    tick_clk();
    reset = 1'b1;
    @(negedge clk);
    check("rst_commit_head_set", o_head_set, 0);
    check("rst_commit_tail_clr", o_tail_clr, 0);
    tick_clk();
    reset = 1'b0;
    @(negedge clk);
    check("rst_commit_after_pulses", o_head_set + o_tail_clr + o_food_req + o_init, 0);
    check("rst_commit_after_busy", o_busy, 1);
    check("rst_commit_after_length", o_len, 0);
    tick_clk();
    body_q.delete(); last_tail = '0; running = 1'b0;

    repeat (150) rand_move();

    // Small instance: saturation at MAX_LEN=4 and pointer wrap.
    sel = 1'b1; model_max = 4;
    do_reset(1'b0);
    add(OP_START, 8'h00, 8'h99, 0, 0, 0, 8'h00, 1, 0);
    add(OP_MOVE,  8'h01, 8'h01, 0, 1, 0, 8'h00, 2, 0);
    add(OP_MOVE,  8'h02, 8'h02, 0, 1, 0, 8'h00, 3, 0);
    add(OP_MOVE,  8'h03, 8'h03, 0, 1, 0, 8'h00, 4, 0);
    add(OP_MOVE,  8'h04, 8'h04, 0, 1, 1, 8'h00, 4, 0);
    add(OP_MOVE,  8'h05, 8'h99, 0, 0, 1, 8'h01, 4, 0);
    add(OP_MOVE,  8'h06, 8'h99, 0, 0, 1, 8'h02, 4, 0);
    add(OP_MOVE,  8'h03, 8'h99, 0, 0, 1, 8'h03, 4, 0);
    add(OP_MOVE,  8'h05, 8'h99, 0, 0, 0, 8'h03, 4, 1);
    add(OP_START, 8'h77, 8'h99, 0, 0, 0, 8'h03, 1, 0);
    run_vecs();

    repeat (100) rand_move();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
